pwm_tick_scheduler: RTL and testbench

Sequences the divided time base of the 50 MHz clock domain into four independent 8-bit PWM channels, e.g. the vibration/servo drives fed from Leap hand data. A synchronous prescaler produces a one-cycle tick enable rather than a derived clock. An 8-bit phase counter advances on each tick. Duty updates arrive over a valid/ready port and are committed glitch-free at period boundaries.

---
 rtl/pwm_tick_scheduler.sv | 112 +++++++++++
 tb/tb_pwm_tick_scheduler.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_tick_scheduler.sv
// Four-channel 8-bit PWM generator driven by a prescaled tick enable.
// Duty updates are shadowed and committed only at period boundaries, or at once while idle.
`timescale 1ns/1ps

module pwm_tick_scheduler #(
  parameter int TICK_DIV = 10,
  parameter int NUM_CH   = 4
) (
  input  logic              clockin50mHz,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [1:0]        cfg_channel,
  input  logic [7:0]        cfg_duty,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              tick,
  output logic              period_start,
  output logic [NUM_CH-1:0] pending
);

  localparam logic [15:0] last_count = 16'(TICK_DIV - 1);

  logic [15:0]       count_reg;
  logic [15:0]       count_next;
  logic [7:0]        phase_reg;
  logic [7:0]        phase_next;
  logic              tick_reg;
  logic              period_start_reg;
  logic              wrap_now;
  logic              boundary;
  logic              transfer;
  logic [NUM_CH-1:0] pending_reg;
  logic [NUM_CH-1:0] pwm_reg;

  // The phase steps on the same edge that raises tick, so tick marks the first
  // cycle of each new phase value and period_start the first cycle of phase 0.
  always_comb begin
    wrap_now   = enable && (count_reg == last_count);
    boundary   = wrap_now && (phase_reg == 8'hff);
    count_next = '0;
    phase_next = '0;
    if (enable) begin
      count_next = wrap_now ? 16'd0 : count_reg + 16'd1;
      phase_next = phase_reg + {7'd0, wrap_now};
    end
  end

  always_ff @(posedge clockin50mHz or negedge reset_n) begin
    if (!reset_n) begin
      count_reg        <= '0;
      phase_reg        <= '0;
      tick_reg         <= 1'b0;
      period_start_reg <= 1'b0;
    end else begin
      count_reg        <= count_next;
      phase_reg        <= phase_next;
      tick_reg         <= wrap_now;
      period_start_reg <= boundary;
    end
  end

  // A channel holding an uncommitted update refuses further writes to it.
  assign cfg_ready = ~pending_reg[cfg_channel];
  assign transfer  = cfg_valid & cfg_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [7:0] shadow_reg;
      logic [7:0] active_reg;
      logic       pending_ch_reg;
      logic       pwm_ch_reg;
      logic       sel;
      logic       commit;

      assign sel    = transfer && (cfg_channel == 2'(gi));
      // Commit reads the pending flag from before this cycle's transfer, so a
      // write landing on the boundary cycle waits for the following boundary.
      assign commit = pending_ch_reg && (boundary || !enable);

      always_ff @(posedge clockin50mHz or negedge reset_n) begin
        if (!reset_n) begin
          shadow_reg     <= '0;
          active_reg     <= '0;
          pending_ch_reg <= 1'b0;
          pwm_ch_reg     <= 1'b0;
        end else begin
          if (sel) begin
            shadow_reg     <= cfg_duty;
            pending_ch_reg <= 1'b1;
          end else if (commit) begin
            pending_ch_reg <= 1'b0;
          end
          if (commit) begin
            active_reg <= shadow_reg;
          end
          pwm_ch_reg <= enable && (phase_reg < active_reg);
        end
      end

      assign pending_reg[gi] = pending_ch_reg;
      assign pwm_reg[gi]     = pwm_ch_reg;
    end
  endgenerate

  assign pwm_out      = pwm_reg;
  assign tick         = tick_reg;
  assign period_start = period_start_reg;
  assign pending      = pending_reg;

endmodule

// File: tb/tb_pwm_tick_scheduler.sv
// Scoreboard bench for pwm_tick_scheduler: the stimulus pushes the expected high-clock
// counts per period, and a monitor measures each period and compares at period_start.
`timescale 1ns/1ps

module tb_pwm_tick_scheduler;

  localparam int TDIV   = 4;
  localparam int PERIOD = 256 * TDIV;
  localparam int LIMIT  = PERIOD + 80;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [1:0] cfg_channel = 2'd0;
  logic [7:0] cfg_duty = 8'd0;
  logic       cfg_ready;
  logic [3:0] pwm_out;
  logic       tick;
  logic       period_start;
  logic [3:0] pending;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0]      tag;
    logic [3:0][15:0] hi;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  pwm_tick_scheduler #(.TICK_DIV(TDIV), .NUM_CH(4)) dut (
    .clockin50mHz(clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_channel (cfg_channel),
    .cfg_duty    (cfg_duty),
    .pwm_out     (pwm_out),
    .tick        (tick),
    .period_start(period_start),
    .pending     (pending)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int tag, input int h0, input int h1, input int h2, input int h3);
    exp_t x;
    x.tag   = 16'(tag);
    x.hi[0] = 16'(h0);
    x.hi[1] = 16'(h1);
    x.hi[2] = 16'(h2);
    x.hi[3] = 16'(h3);
    sb.push_back(x);
  endtask

  // ---------------- monitor ----------------
  int cyc = 0;
  int periods_done = 0;
  int tick_last = 0;
  int ps_last = 0;
  int acc[4];
  bit idle = 1'b1;
  bit rst_hit = 1'b0;

  always @(negedge reset_n) rst_hit = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (!reset_n || !enable) begin
      idle = 1'b1;
      for (int i = 0; i < 4; i++) acc[i] = 0;
    end else begin
      if (idle || rst_hit) begin
        idle      = 1'b0;
        rst_hit   = 1'b0;
        tick_last = cyc;
        ps_last   = cyc;
        for (int i = 0; i < 4; i++) acc[i] = 0;
      end
      for (int i = 0; i < 4; i++) acc[i] += int'(pwm_out[i]);
      if (tick) begin
        chk("tick_spacing", cyc - tick_last, TDIV);
        tick_last = cyc;
      end
      if (period_start) begin
        chk("period_spacing", cyc - ps_last, PERIOD);
        ps_last = cyc;
        while (sb.size() > 0 && int'(sb[0].tag) < periods_done) begin
          checks++;
          errors++;
          $display("FAIL window_missed: got no window %0d, expected one", int'(sb[0].tag));
          void'(sb.pop_front());
        end
        if (sb.size() > 0 && int'(sb[0].tag) == periods_done) begin
          e = sb.pop_front();
          $display("window %0d: high clocks %0d %0d %0d %0d", periods_done,
                   acc[0], acc[1], acc[2], acc[3]);
          for (int i = 0; i < 4; i++)
            chk($sformatf("w%0d_ch%0d_high", periods_done, i), acc[i], int'(e.hi[i]));
        end
        periods_done++;
        for (int i = 0; i < 4; i++) acc[i] = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_ps_edge();
    int n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!period_start && n < LIMIT);
    if (!period_start) begin
      checks++;
      errors++;
      $display("FAIL period_start_timeout: got none in %0d cycles, expected one", LIMIT);
    end
  endtask

  task automatic wait_ps();
    wait_ps_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic do_write(input int ch, input int duty, output int stalls, output int ps_x);
    @(posedge clk);
    #1;
    cfg_channel = 2'(ch);
    cfg_duty    = 8'(duty);
    cfg_valid   = 1'b1;
    stalls      = 0;
    ps_x        = 0;
    forever begin
      @(negedge clk);
      if (cfg_ready) begin
        ps_x = int'(period_start);
        break;
      end
      stalls++;
      if (stalls > LIMIT) begin
        checks++;
        errors++;
        $display("FAIL write_timeout: got cfg_ready=0 for %0d cycles, expected 1", stalls);
        break;
      end
    end
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    $display("write ch%0d duty %0d after %0d stall cycles", ch, duty, stalls);
  endtask

  initial begin
    int st;
    int px;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_pwm_out", int'(pwm_out), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_period_start", int'(period_start), 0);
    chk("rst_cfg_ready", int'(cfg_ready), 1);

    // Run with no writes: two all-zero periods.
    reset_n = 1'b1;
    enable  = 1'b1;
    push(0, 0, 0, 0, 0);
    push(1, 0, 0, 0, 0);
    wait_ps();

    // Basic duties, committed at the end of period 1.
    do_write(0, 64, st, px);
    do_write(1, 128, st, px);
    do_write(2, 255, st, px);
    do_write(3, 0, st, px);
    chk("basic_pending_set", int'(pending), 4'hf);
    push(2, 256, 512, 1020, 0);
    wait_ps();
    chk("basic_pending_clear", int'(pending), 0);

    // Backpressure: the second ch1 write stalls until the boundary.
    push(3, 256, 40, 1020, 0);
    push(4, 256, 800, 1020, 0);
    do_write(1, 10, st, px);
    chk("bp_first_stalls", st, 0);
    do_write(1, 200, st, px);
    chk("bp_second_stalled", int'(st > 0), 1);
    chk("bp_xfer_in_ps_cycle", px, 1);
    chk("bp_pending", int'(pending), 4'h2);
    wait_ps();
    chk("bp_pending_clear", int'(pending), 0);

    // Boundary collision: ch2 written during a period_start cycle.
    push(5, 256, 800, 1020, 0);
    wait_ps_edge();
    cfg_channel = 2'd2;
    cfg_duty    = 8'd32;
    cfg_valid   = 1'b1;
    #1;
    chk("coll_cfg_ready", int'(cfg_ready), 1);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    chk("coll_pending_kept", int'(pending), 4'h4);
    do_write(0, 128, st, px);
    chk("coll_ch0_pending", int'(pending), 4'h5);
    wait_ps();
    chk("coll_pending_clear", int'(pending), 0);

    // Enable toggle at phase 50 with ch0 at duty 128.
    repeat (200) @(posedge clk);
    #1;
    chk("en_pwm0_high_phase50", int'(pwm_out[0]), 1);
    enable = 1'b0;
    @(posedge clk);
    #1;
    chk("en_pwm_low", int'(pwm_out), 0);
    do_write(0, 16, st, px);
    chk("idle_pending_set", int'(pending), 4'h1);
    @(posedge clk);
    #1;
    chk("idle_pending_clear", int'(pending), 0);
    chk("idle_cfg_ready", int'(cfg_ready), 1);
    chk("idle_pwm_low", int'(pwm_out), 0);
    @(posedge clk);
    #1;
    enable = 1'b1;
    push(6, 64, 800, 128, 0);
    wait_ps();

    // Asynchronous reset pulse while ch0 is high.
    repeat (10) @(posedge clk);
    #5;
    chk("ar_pwm0_high", int'(pwm_out[0]), 1);
    reset_n = 1'b0;
    #1;
    chk("ar_pwm_low", int'(pwm_out), 0);
    chk("ar_pending", int'(pending), 0);
    chk("ar_tick", int'(tick), 0);
    chk("ar_cfg_ready", int'(cfg_ready), 1);
    #2;
    reset_n = 1'b1;
    push(7, 0, 0, 0, 0);
    wait_ps();
    chk("ar_pending_after", int'(pending), 0);
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
